// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus: decode/memory side (master) and fetch unit (slave).
// Carries the hazard hold, the decode redirect, the memory word and the IF/ID outputs.
interface mips_fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        active;
  logic        fetch_fault;

  modport master (
    output stall, redirect_valid, redirect_target, instr_in,
    input  pc, id_instr, id_pc, id_valid, active, fetch_fault
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, instr_in,
    output pc, id_instr, id_pc, id_valid, active, fetch_fault
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: program counter, IF/ID register, branch delay slot
// handling and halt-on-jump-to-zero.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input logic              clk,
  input logic              reset,
  mips_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] saved_target;

  // A taken redirect is parked in saved_target while the delay slot is fetched,
  // then resolved into a jump, a halt or a fault on the following advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      saved_target    <= 32'd0;
      bus.pc          <= RESET_VECTOR;
      bus.id_instr    <= 32'd0;
      bus.id_pc       <= 32'd0;
      bus.id_valid    <= 1'b0;
      bus.active      <= 1'b1;
      bus.fetch_fault <= 1'b0;
    end else if (state == HALTED) begin
      bus.id_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.id_instr <= bus.instr_in;
      bus.id_pc    <= bus.pc;
      bus.id_valid <= 1'b1;
      case (state)
        RUN: begin
          bus.pc <= bus.pc + 32'd4;
          if (bus.redirect_valid) begin
            saved_target <= bus.redirect_target;
            state        <= DELAY;
          end
        end
        DELAY: begin
          if (saved_target == HALT_ADDR) begin
            bus.pc     <= HALT_ADDR;
            bus.active <= 1'b0;
            state      <= HALTED;
          end else if (saved_target[1:0] != 2'b00) begin
            bus.fetch_fault <= 1'b1;
            bus.active      <= 1'b0;
            state           <= HALTED;
          end else begin
            bus.pc <= saved_target;
            state  <= RUN;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios then randomized
// stimulus compared each cycle against a behavioural fetch model.
module tb_mips_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  mips_fetch_unit_if bus();

  mips_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
  endfunction

  assign bus.instr_in = memWord(bus.pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a pending-branch flag plus the architectural registers.
  logic [31:0] mPc, mTarget, mIdInstr, mIdPc;
  logic        mPending, mHalted, mIdValid, mActive, mFault;

  task automatic modelStep(input logic st, input logic rv, input logic [31:0] rt,
                           input logic rs);
    if (rs) begin
      mPc = RV; mTarget = 0; mPending = 0; mHalted = 0;
      mIdInstr = 0; mIdPc = 0; mIdValid = 0; mActive = 1; mFault = 0;
    end else if (mHalted) begin
      mIdValid = 0;
    end else if (!st) begin
      mIdInstr = memWord(mPc);
      mIdPc    = mPc;
      mIdValid = 1;
      if (mPending) begin
        mPending = 0;
        if (mTarget == 0) begin
          mPc = 0; mHalted = 1; mActive = 0;
        end else if (mTarget % 4 != 0) begin
          mFault = 1; mHalted = 1; mActive = 0;
        end else begin
          mPc = mTarget;
        end
      end else begin
        if (rv) begin
          mPending = 1;
          mTarget  = rt;
        end
        mPc = mPc + 32'd4;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("pc", bus.pc, mPc);
    checkOutput("id_instr", bus.id_instr, mIdInstr);
    checkOutput("id_pc", bus.id_pc, mIdPc);
    checkOutput("id_valid", {31'd0, bus.id_valid}, {31'd0, mIdValid});
    checkOutput("active", {31'd0, bus.active}, {31'd0, mActive});
    checkOutput("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, mFault});
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt,
                               input logic rs);
    reset               = rs;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    @(posedge clk);
    #1;
    modelStep(st, rv, rt, rs);
    checkAll();
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] tgt;
    logic        rs, st, rv;
    checkCount = 0;
    failCount  = 0;
    reset = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 0;
    mPc = 0; mTarget = 0; mIdInstr = 0; mIdPc = 0;
    mPending = 0; mHalted = 0; mIdValid = 0; mActive = 0; mFault = 0;
    #2;

    // Reset, then sequential fetch.
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset_pc", bus.pc, 32'hBFC00000);
    repeat (2) applyStimulus(0, 0, 0, 0);
    checkOutput("seq_pc", bus.pc, 32'hBFC00008);

    // Branch with delay slot.
    applyStimulus(0, 1, 32'hBFC00100, 0);
    checkOutput("delay_slot_pc", bus.pc, 32'hBFC0000C);
    applyStimulus(0, 0, 0, 0);
    checkOutput("target_pc", bus.pc, 32'hBFC00100);
    applyStimulus(0, 0, 0, 0);

    // Stall while a branch is pending; target taken once after release.
    applyStimulus(0, 1, 32'hBFC00200, 0);
    repeat (3) applyStimulus(1, 1, 32'hBFC00400, 0);
    applyStimulus(0, 1, 32'hBFC00400, 0);
    checkOutput("stall_target_pc", bus.pc, 32'hBFC00200);
    applyStimulus(0, 0, 0, 0);

    // Wrap past the top of the address space does not halt.
    applyStimulus(0, 1, 32'hFFFFFFF8, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_active", {31'd0, bus.active}, 32'd1);

    // Reset mid-DELAY discards the pending target.
    applyStimulus(0, 1, 32'hBFC00300, 0);
    applyStimulus(0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 0);

    // Misaligned target faults; reset clears it.
    applyStimulus(0, 1, 32'hBFC00102, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("fault_flag", {31'd0, bus.fetch_fault}, 32'd1);
    applyStimulus(0, 0, 0, 1);

    // Jump to zero halts after the delay slot.
    applyStimulus(0, 1, 32'h00000000, 0);
    repeat (4) applyStimulus(0, 0, 0, 0);
    checkOutput("halt_pc", bus.pc, 32'h00000000);
    applyStimulus(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rs  = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      rnd = $urandom;
      case ($urandom_range(0, 19))
        0:       tgt = 32'h00000000;
        1:       tgt = {rnd[31:2], 2'b10};
        default: tgt = {rnd[31:2], 2'b00};
      endcase
      applyStimulus(st, rv, tgt, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
